// File: rtl/otter_fetch_queue_pkg.sv
// otter_fetch_pkg: shared widths, queue entry type and default reset vector for the fetch stage
package otter_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEF_RESET_VEC = '0;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } fetch_entry_t;
endpackage

// File: rtl/otter_fetch_queue_if.sv
// otter_fetch_if: memory port 1, decode handshake and redirect request of the fetch stage
interface otter_fetch_if;
  logic [31:0] mem_addr1;
  logic        mem_read1;
  logic [31:0] mem_dout1;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_ir;
  logic [31:0] if_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  modport master (output mem_addr1, mem_read1, if_valid, if_ir, if_pc,
                  input mem_dout1, if_ready, redirect, redirect_pc);
  modport slave (input mem_addr1, mem_read1, if_valid, if_ir, if_pc,
                 output mem_dout1, if_ready, redirect, redirect_pc);
endinterface

// File: rtl/otter_fifo.sv
// otter_fifo: generic synchronous FIFO with flush; push and pop may coincide at any fill level
module otter_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0]
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  T                           din,
  output T                           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  T mem [DEPTH];
  logic [AW-1:0] rd, wr;
  assign dout  = mem[rd];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= din;
endmodule

// File: rtl/otter_fetch_queue.sv
// otter_fetch_queue: sequential instruction fetch into a DEPTH-entry queue with redirect flush.
// Define OTTER_FETCH_BYPASS_EN to forward a response straight to decode while the queue is empty.
module otter_fetch_queue
  import otter_fetch_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC
) (
  input logic          clk,
  input logic          rst_n,
  otter_fetch_if.master bus
);
  logic [31:0] fetch_pc, inflight_pc;
  logic inflight, full, empty, push, pop, bypass;
  logic [$clog2(DEPTH+1)-1:0] count;
  fetch_entry_t head, resp;
  always_comb begin
    bus.mem_read1 = rst_n && (bus.redirect || (!full && int'(count) + int'(inflight) < DEPTH));
    bus.mem_addr1 = (rst_n && bus.redirect) ? {bus.redirect_pc[31:2], 2'b00} : fetch_pc;
`ifdef OTTER_FETCH_BYPASS_EN
    bypass = empty && inflight && !bus.redirect;
`else
    bypass = 1'b0;
`endif
    resp = '{pc: inflight_pc, ir: bus.mem_dout1};
    bus.if_valid = !bus.redirect && (!empty || bypass);
    {bus.if_pc, bus.if_ir} = !bus.if_valid ? 64'd0 : bypass ? {resp.pc, resp.ir} : {head.pc, head.ir};
    // a redirect discards whatever response lands in its own cycle
    push = inflight && !bus.redirect && !(bypass && bus.if_ready);
    pop  = bus.if_valid && bus.if_ready && !empty;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc    <= RESET_VEC;
      inflight_pc <= RESET_VEC;
      inflight    <= 1'b0;
    end else begin
      inflight <= bus.mem_read1;
      if (bus.mem_read1) begin
        fetch_pc    <= bus.mem_addr1 + 32'd4;
        inflight_pc <= bus.mem_addr1;
      end
    end
  otter_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(bus.redirect),
    .din(resp), .dout(head), .count(count), .full(full), .empty(empty)
  );
endmodule

// File: tb/tb_otter_fetch_queue.sv
// tb_otter_fetch_queue: randomized and directed checks of the fetch queue against a queue-based reference model
module tb_otter_fetch_queue;
  import otter_fetch_pkg::*;
  localparam int DEPTH = 4;
`ifdef OTTER_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  otter_fetch_if bus();
  otter_fetch_queue #(.DEPTH(DEPTH), .RESET_VEC(32'h0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int vectors = 0;
  int errors = 0;
  fetch_entry_t q[$];
  logic m_infl, prev_rd, seq_ok;
  logic [31:0] m_ipc, m_fpc, prev_addr, last_pop;
  logic o_rd, o_valid;
  logic [31:0] o_addr, o_pc, o_ir;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  task automatic model_reset();
    q.delete();
    m_infl = 1'b0; m_ipc = '0; m_fpc = '0;
    prev_rd = 1'b0; prev_addr = '0; seq_ok = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask
  // one clock cycle: drive inputs at the falling edge, sample and score 1 ns later
  task automatic step(input logic red, input logic [31:0] rpc, input logic rdy);
    logic e_rd, e_valid, byp;
    logic [31:0] e_addr, e_pc;
    bus.redirect = red; bus.redirect_pc = rpc; bus.if_ready = rdy;
    bus.mem_dout1 = prev_rd ? mem_word(prev_addr) : $urandom();
    #1;
    o_rd = bus.mem_read1; o_addr = bus.mem_addr1; o_valid = bus.if_valid;
    o_pc = bus.if_pc; o_ir = bus.if_ir;
    byp = BYP && q.size() == 0 && m_infl && !red;
    e_rd = red || (q.size() + int'(m_infl) < DEPTH);
    e_addr = red ? {rpc[31:2], 2'b00} : m_fpc;
    e_valid = !red && (q.size() != 0 || byp);
    e_pc = byp ? m_ipc : (q.size() != 0 ? q[0].pc : 32'h0);
    vectors++;
    if (o_rd !== e_rd) begin errors++; $display("FAIL mem_read1 got %b want %b at %0t", o_rd, e_rd, $time); end
    vectors++;
    if (o_addr !== e_addr) begin errors++; $display("FAIL mem_addr1 got %h want %h at %0t", o_addr, e_addr, $time); end
    vectors++;
    if (o_valid !== e_valid) begin errors++; $display("FAIL if_valid got %b want %b at %0t", o_valid, e_valid, $time); end
    vectors++;
    if (int'(dut.count) != q.size()) begin errors++; $display("FAIL count got %0d want %0d at %0t", dut.count, q.size(), $time); end
    if (e_valid) begin
      vectors++;
      if (o_pc !== e_pc) begin errors++; $display("FAIL if_pc got %h want %h at %0t", o_pc, e_pc, $time); end
      vectors++;
      if (o_ir !== mem_word(e_pc)) begin errors++; $display("FAIL if_ir got %h want %h at %0t", o_ir, mem_word(e_pc), $time); end
    end
    if (o_valid && rdy && seq_ok) begin
      vectors++;
      if (o_pc !== last_pop + 32'd4) begin errors++; $display("FAIL pop_order got %h want %h", o_pc, last_pop + 32'd4); end
    end
    if (red) seq_ok = 1'b0;
    if (o_valid && rdy) begin last_pop = o_pc; seq_ok = 1'b1; end
    if (red) q.delete();
    else begin
      if (e_valid && rdy && q.size() != 0) void'(q.pop_front());
      if (m_infl && !(byp && rdy)) q.push_back('{pc: m_ipc, ir: mem_word(m_ipc)});
    end
    m_infl = e_rd;
    if (e_rd) begin m_ipc = e_addr; m_fpc = e_addr + 32'd4; end
    prev_rd = o_rd; prev_addr = o_addr;
    @(negedge clk);
  endtask
  task automatic test_reset();
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.if_ready = 1'b1; bus.mem_dout1 = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (bus.mem_read1 !== 1'b0 || bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_strobes rd=%b valid=%b want 0 0", bus.mem_read1, bus.if_valid); end
    vectors++;
    if (bus.if_ir !== 32'h0 || bus.if_pc !== 32'h0) begin errors++; $display("FAIL reset_outputs ir=%h pc=%h want 0 0", bus.if_ir, bus.if_pc); end
    vectors++;
    if (bus.mem_addr1 !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.mem_addr1); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask
  task automatic test_first_fetch();
    int start;
    start = BYP ? 1 : 2;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 32'h0, 1'b1);
      if (c < 3) begin
        vectors++;
        if (!o_rd || o_addr !== 32'(4 * c)) begin errors++; $display("FAIL first_addr c%0d rd=%b addr=%h want %h", c, o_rd, o_addr, 4 * c); end
      end
      if (c >= start) begin
        vectors++;
        if (!o_valid || o_pc !== 32'(4 * (c - start))) begin errors++; $display("FAIL first_pc c%0d valid=%b pc=%h want %h", c, o_valid, o_pc, 4 * (c - start)); end
      end
    end
  endtask
  task automatic test_backpressure();
    int reads;
    logic [31:0] got[$];
    logic [31:0] first_addr;
    logic seen;
    do_reset();
    reads = 0;
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 32'h0, 1'b0);
      reads += int'(o_rd);
    end
    vectors++;
    if (reads != DEPTH || o_rd !== 1'b0) begin errors++; $display("FAIL full_reads got %0d last_rd=%b want %0d 0", reads, o_rd, DEPTH); end
    vectors++;
    if (int'(dut.count) != DEPTH) begin errors++; $display("FAIL full_count got %0d want %0d", dut.count, DEPTH); end
    seen = 1'b0; first_addr = '0;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 32'h0, 1'b1);
      if (o_valid) got.push_back(o_pc);
      if (o_rd && !seen) begin seen = 1'b1; first_addr = o_addr; end
    end
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (c >= got.size() || got[c] !== 32'(4 * c)) begin errors++; $display("FAIL drain_order idx%0d got %h want %h", c, c < got.size() ? got[c] : 32'hX, 4 * c); end
    end
    vectors++;
    if (!seen || first_addr !== 32'd16) begin errors++; $display("FAIL resume_addr seen=%b got %h want 10", seen, first_addr); end
  endtask
  task automatic test_redirect();
    logic found;
    do_reset();
    for (int c = 0; c < 4; c++) step(1'b0, 32'h0, 1'b0);
    vectors++;
    if (int'(dut.count) != 3 || !prev_rd) begin errors++; $display("FAIL redirect_setup count=%0d inflight=%b want 3 1", dut.count, prev_rd); end
    step(1'b1, 32'h0000_0103, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      step(1'b0, 32'h0, 1'b1);
      if (o_valid) begin
        found = 1'b1;
        vectors++;
        if (o_pc !== 32'h100) begin errors++; $display("FAIL redirect_pc got %h want 00000100", o_pc); end
      end
    end
    if (!found) begin vectors++; errors++; $display("FAIL redirect_timeout got none want 00000100"); end
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 32'h0, 1'($urandom_range(0, 1)));
      if (o_valid) begin
        vectors++;
        if (o_pc < 32'h100) begin errors++; $display("FAIL stale_pc got %h want >= 00000100", o_pc); end
      end
    end
  endtask
  task automatic test_wrap();
    logic [31:0] exp_pc[3];
    logic [31:0] got[$];
    exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int c = 0; c < 10 && got.size() < 3; c++) begin
      step(1'b0, 32'h0, 1'b1);
      if (o_valid) got.push_back(o_pc);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (i >= got.size() || got[i] !== exp_pc[i]) begin errors++; $display("FAIL wrap idx%0d got %h want %h", i, i < got.size() ? got[i] : 32'hX, exp_pc[i]); end
    end
  endtask
  task automatic test_full_pushpop();
    logic [31:0] got[$];
    do_reset();
    for (int c = 0; c < 7; c++) step(1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 32'h0, 1'b1);
      if (o_valid) got.push_back(o_pc);
      vectors++;
      if (int'(dut.count) > DEPTH) begin errors++; $display("FAIL overfill got %0d want <= %0d", dut.count, DEPTH); end
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (i >= got.size() || got[i] !== 32'(4 * i)) begin errors++; $display("FAIL pushpop_order idx%0d got %h want %h", i, i < got.size() ? got[i] : 32'hX, 4 * i); end
    end
  endtask
  task automatic test_random();
    logic [31:0] rpc;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom();
      step(1'($urandom_range(0, 19) == 0), rpc, 1'($urandom_range(0, 3) != 0));
    end
  endtask
  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 5; c++) step(1'b0, 32'h0, 1'b0);
    bus.if_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.if_valid !== 1'b0 || bus.mem_read1 !== 1'b0) begin errors++; $display("FAIL async_reset valid=%b rd=%b want 0 0", bus.if_valid, bus.mem_read1); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 6; c++) step(1'b0, 32'h0, 1'b1);
  endtask
  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_full_pushpop();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
